// File: rtl/rv32_pkg.sv
// Shared RV32 fetch definitions: data width, fetch FSM states, reset vector.
package rv32_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_VEC = '0;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2,
    FS_ERR  = 2'd3
  } fetch_state_t;

  // Sequential successor of a PC, wrapping modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INST_BYTES);
  endfunction

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Architectural PC register with load enable; shared with the single-cycle core.
module pc_reg
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_VEC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc
);

  // Hold the PC; take next_pc only when load is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: one outstanding imem request, no prefetch,
// redirects squash in-flight fetches, misaligned redirect traps to ERR.
module instr_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_VEC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc_plus4,
  output logic            fetch_misaligned
);

  fetch_state_t    state;
  logic            kill;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] pc;
  logic            pc_load;
  logic [XLEN-1:0] pc_next;
  logic            redir_ok;
  logic            redir_bad;
  logic            accept;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pc_load),
    .next_pc (pc_next),
    .pc      (pc)
  );

  assign imem_req_addr = pc;
  assign accept        = imem_req_valid & imem_req_ready;

  // Classify the redirect and pick the next PC: redirect beats sequential advance.
  always_comb begin
    redir_ok  = redirect_valid & is_word_aligned(redirect_pc);
    redir_bad = redirect_valid & ~is_word_aligned(redirect_pc);
    pc_load   = 1'b0;
    pc_next   = pc;
    if (state != FS_ERR) begin
      if (redir_ok) begin
        pc_load = 1'b1;
        pc_next = redirect_pc;
      end else if (!redir_bad && state == FS_HOLD && inst_ready) begin
        pc_load = 1'b1;
        pc_next = inst_pc_plus4;
      end
    end
  end

  // Fetch FSM with registered request/instruction outputs and the squash flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= FS_REQ;
      kill             <= 1'b0;
      req_pc           <= '0;
      imem_req_valid   <= 1'b0;
      inst_valid       <= 1'b0;
      inst_data        <= '0;
      inst_pc          <= '0;
      inst_pc_plus4    <= '0;
      fetch_misaligned <= 1'b0;
    end else if (redir_bad) begin
      // A misaligned target traps from any state; any outstanding response is orphaned.
      fetch_misaligned <= 1'b1;
      state            <= FS_ERR;
      kill             <= 1'b0;
      imem_req_valid   <= 1'b0;
      inst_valid       <= 1'b0;
    end else begin
      unique case (state)
        FS_REQ: begin
          imem_req_valid <= 1'b1;
          if (accept) begin
            req_pc         <= pc;
            kill           <= redir_ok;
            imem_req_valid <= 1'b0;
            state          <= FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (imem_rsp_valid) begin
            if (kill || redir_ok) begin
              kill           <= 1'b0;
              imem_req_valid <= 1'b1;
              state          <= FS_REQ;
            end else begin
              inst_data     <= imem_rsp_data;
              inst_pc       <= req_pc;
              inst_pc_plus4 <= pc_plus4(req_pc);
              inst_valid    <= 1'b1;
              state         <= FS_HOLD;
            end
          end else if (redir_ok) begin
            kill <= 1'b1;
          end
        end
        FS_HOLD: begin
          if (inst_ready || redir_ok) begin
            inst_valid     <= 1'b0;
            imem_req_valid <= 1'b1;
            state          <= FS_REQ;
          end
        end
        FS_ERR: begin
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a random
// phase, checked against a transaction-level fetch model and a memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        fetch_misaligned;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_data        (inst_data),
    .inst_pc          (inst_pc),
    .inst_pc_plus4    (inst_pc_plus4),
    .fetch_misaligned (fetch_misaligned)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Fetch model: next address to fetch, one in-flight fetch (maybe squashed),
  // one instruction held for decode, trap flag.
  bit          m_first, m_out, m_sq, m_held, m_err, m_mis;
  logic [31:0] m_next, m_oaddr, m_hpc, m_hdata;

  // Memory model: one scheduled response.
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat = 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    if (a == 32'h0000_0200) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic bit exp_req();
    return !m_first && !m_err && !m_out && !m_held;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_first = 1; m_out = 0; m_sq = 0; m_held = 0; m_err = 0; m_mis = 0;
    m_next = 32'h0000_0000;
  endtask

  task automatic check_outputs();
    check("req_valid", 32'(imem_req_valid), 32'(exp_req()));
    if (exp_req()) check("req_addr", imem_req_addr, m_next);
    check("inst_valid", 32'(inst_valid), 32'(m_held));
    if (m_held) begin
      check("inst_pc", inst_pc, m_hpc);
      check("inst_data", inst_data, m_hdata);
      check("inst_pc_plus4", inst_pc_plus4, m_hpc + 32'd4);
    end
    check("misaligned", 32'(fetch_misaligned), 32'(m_mis));
  endtask

  // One clock cycle: check, drive, clock, update models. Entered and left at negedge.
  task automatic step(input bit rr, input bit ir, input bit rv, input logic [31:0] rpc);
    bit          acc, rsp, new_held;
    logic [31:0] nh_pc, nh_data;
    check_outputs();
    acc = exp_req() && rr;
    imem_req_ready = rr;
    inst_ready     = ir;
    redirect_valid = rv;
    redirect_pc    = rpc;
    rsp = mem_busy && (mem_cnt == 0);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memf(mem_addr) : $urandom;
    @(posedge clk);
    if (rsp) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (acc) begin
      mem_busy = 1; mem_cnt = lat - 1; mem_addr = m_next;
    end
    m_first = 0;
    if (m_err) begin
    end else if (rv && rpc[1:0] != 2'b00) begin
      m_err = 1; m_mis = 1; m_held = 0; m_out = 0;
    end else begin
      new_held = m_held && !ir;
      nh_pc    = m_hpc;
      nh_data  = m_hdata;
      if (m_held && ir) m_next = m_hpc + 32'd4;
      if (m_out && rsp) begin
        if (!m_sq && !rv) begin
          new_held = 1; nh_pc = m_oaddr; nh_data = memf(m_oaddr);
        end
        m_out = 0;
      end
      if (acc) begin
        m_out = 1; m_oaddr = m_next; m_sq = 0;
      end
      if (rv) begin
        m_next = rpc;
        if (m_out) m_sq = 1;
        new_held = 0;
      end
      m_held = new_held; m_hpc = nh_pc; m_hdata = nh_data;
    end
    @(negedge clk);
  endtask

  function automatic bit cond_met(input int what);
    case (what)
      0:       return m_held;
      1:       return m_out && !m_sq;
      2:       return m_out;
      default: return exp_req();
    endcase
  endfunction

  // Step until a model condition holds, bounded; an expired bound is a failure.
  task automatic run_until(input int what, input int maxc, input bit rr, input bit ir);
    for (int i = 0; i < maxc && !cond_met(what); i++) step(rr, ir, 0, 32'h0);
    check("wait_bound", 32'(cond_met(what)), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_inst_data"}, inst_data, 32'd0);
    check({tag, "_inst_pc"}, inst_pc, 32'd0);
    check({tag, "_inst_pc4"}, inst_pc_plus4, 32'd0);
    check({tag, "_misaligned"}, 32'(fetch_misaligned), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tgt;
    rst_n = 0; redirect_valid = 0; redirect_pc = '0; imem_req_ready = 0;
    imem_rsp_valid = 0; imem_rsp_data = '0; inst_ready = 0;
    model_reset(); mem_busy = 0; mem_cnt = 0; mem_addr = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1;

    // Sequential fetch from reset vector, zero-wait memory.
    lat = 1;
    repeat (9) step(1, 1, 0, 32'h0);

    // Decode backpressure at 0x100.
    step(1, 1, 1, 32'h100);
    run_until(0, 20, 1, 0);
    check("bp_inst_pc", inst_pc, 32'h100);
    repeat (5) step(1, 0, 0, 32'h0);
    step(1, 1, 0, 32'h0);
    run_until(3, 20, 0, 1);
    check("bp_next_addr", imem_req_addr, 32'h104);

    // Redirect while waiting for the response of 0x200.
    lat = 2;
    step(1, 1, 1, 32'h200);
    run_until(1, 20, 1, 1);
    step(1, 1, 1, 32'h240);
    run_until(0, 20, 1, 0);
    check("wait_redir_pc", inst_pc, 32'h240);
    step(1, 1, 0, 32'h0);

    // Redirect in the same cycle the request for 0x300 is accepted.
    lat = 1;
    step(1, 1, 1, 32'h300);
    run_until(3, 20, 0, 1);
    check("coinc_addr", imem_req_addr, 32'h300);
    step(1, 1, 1, 32'h5F0);
    run_until(0, 20, 1, 0);
    check("coinc_inst_pc", inst_pc, 32'h5F0);
    step(1, 1, 0, 32'h0);

    // PC+4 wrap at the top of the address space.
    step(1, 1, 1, 32'hFFFF_FFFC);
    run_until(0, 20, 1, 0);
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", inst_pc_plus4, 32'h0);
    step(1, 1, 0, 32'h0);
    run_until(3, 20, 0, 1);
    check("wrap_next_addr", imem_req_addr, 32'h0);

    // Random traffic with aligned redirects.
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 3);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFFC;
      step(($urandom % 10) < 7, ($urandom % 10) < 6, ($urandom % 100) < 8, tgt);
    end

    // Asynchronous reset while a response is outstanding.
    lat = 3;
    run_until(2, 40, 1, 1);
    #2 rst_n = 0;
    #1 check_reset_outputs("async");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (4) step(0, 1, 0, 32'h0);
    lat = 1;
    repeat (9) step(1, 1, 0, 32'h0);

    // Misaligned redirect while holding an instruction.
    run_until(0, 20, 1, 0);
    step(1, 0, 1, 32'h1006);
    check("mis_flag", 32'(fetch_misaligned), 32'd1);
    check("mis_inst_valid", 32'(inst_valid), 32'd0);
    repeat (4) step(1, 1, 0, 32'h0);
    step(1, 1, 1, 32'h400);
    repeat (4) step(1, 1, 0, 32'h0);
    rst_n = 0;
    #1 check("mis_cleared", 32'(fetch_misaligned), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (6) step(1, 1, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
